// File: rtl/i2c_codec_slave.sv
// i2c_codec_slave: oversampled I2C write-responder with a 16-entry shadow file.
// Define I2C_SLV_READ_EN to build the R/W=1 read-back path.
module i2c_codec_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       oREG_WE,
  output logic [6:0] oREG_ADDR,
  output logic [8:0] oREG_DATA,
  output logic       oBUSY,
  output logic       oACTIVE,
  input  logic [3:0] iDBG_ADDR,
  output logic [8:0] oDBG_DATA
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, BYTE1,
    ACK1, BYTE2, ACK2, IGNORE
`ifdef I2C_SLV_READ_EN
    , RD_BYTE, RD_ACK
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [6:0] ra_q, ra_d;
  logic       d8_q, d8_d;
  logic       commit;
  logic       sda_oe;

  logic [2:0] scl_q, sda_q;
  logic       scl_rise, scl_fall;
  logic       start, stop;

  logic [8:0] shadow_q [16];
  logic       we_q;
  logic [6:0] addr_q;
  logic [8:0] data_q;
  logic       active_q;

`ifdef I2C_SLV_READ_EN
  logic       rd_q, rd_d;
  logic       hi_q, hi_d;
  logic [8:0] rd_data;
  assign rd_data = (addr_q < 7'h0F)
                 ? shadow_q[addr_q[3:0]] : 9'h000;
`endif

  // Idle-bus reset values keep a reset release from looking like an edge
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], I2C_SCLK};
      sda_q <= {sda_q[1:0], I2C_SDAT};
    end
  end

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start = scl_q[1] & scl_q[2]
               & sda_q[2] & ~sda_q[1];
  assign stop  = scl_q[1] & scl_q[2]
               & ~sda_q[2] & sda_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ra_d    = ra_q;
    d8_d    = d8_q;
    commit  = 1'b0;
`ifdef I2C_SLV_READ_EN
    rd_d    = rd_q;
    hi_d    = hi_q;
`endif
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        ADDR, BYTE1, BYTE2: begin
          if (scl_rise && cnt_q != 4'd8) begin
            sh_d  = {sh_q[6:0], sda_q[1]};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            unique case (state_q)
              ADDR: begin
                state_d = IGNORE;
                if (sh_q[7:1] == SLAVE_ADDR && !sh_q[0]) begin
                  state_d = ADDR_ACK;
`ifdef I2C_SLV_READ_EN
                  rd_d    = 1'b0;
                end else if (sh_q[7:1] == SLAVE_ADDR) begin
                  state_d = ADDR_ACK;
                  rd_d    = 1'b1;
`endif
                end
              end
              BYTE1: begin
                ra_d    = sh_q[7:1];
                d8_d    = sh_q[0];
                state_d = ACK1;
              end
              default: begin
                commit  = 1'b1;
                state_d = ACK2;
              end
            endcase
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d   = 4'd0;
            state_d = BYTE1;
`ifdef I2C_SLV_READ_EN
            if (rd_q) begin
              state_d = RD_BYTE;
              sh_d    = {addr_q, rd_data[8]};
              hi_d    = 1'b0;
            end
`endif
          end
        end
        ACK1: if (scl_fall) state_d = BYTE2;
        ACK2: if (scl_fall) state_d = IGNORE;
`ifdef I2C_SLV_READ_EN
        RD_BYTE: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              state_d = RD_ACK;
              cnt_d   = 4'd0;
            end else begin
              sh_d  = {sh_q[6:0], 1'b1};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            sh_d[0] = sda_q[1];
          end else if (scl_fall) begin
            state_d = IGNORE;
            if (!sh_q[0] && !hi_q) begin
              state_d = RD_BYTE;
              sh_d    = rd_data[7:0];
              hi_d    = 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 8'h00;
      ra_q    <= 7'h00;
      d8_q    <= 1'b0;
`ifdef I2C_SLV_READ_EN
      rd_q    <= 1'b0;
      hi_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ra_q    <= ra_d;
      d8_q    <= d8_d;
`ifdef I2C_SLV_READ_EN
      rd_q    <= rd_d;
      hi_q    <= hi_d;
`endif
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      we_q     <= 1'b0;
      addr_q   <= 7'h00;
      data_q   <= 9'h000;
      active_q <= 1'b0;
      for (int i = 0; i < 16; i++)
        shadow_q[i] <= 9'h000;
    end else begin
      we_q     <= commit;
      active_q <= shadow_q[9][0];
      if (commit) begin
        addr_q <= ra_q;
        data_q <= {d8_q, sh_q};
        unique case (1'b1)
          (ra_q < 7'h0F):
            shadow_q[ra_q[3:0]] <= {d8_q, sh_q};
          (ra_q == 7'h0F):
            for (int i = 0; i < 15; i++)
              shadow_q[i] <= 9'h000;
          default: ;
        endcase
      end
    end
  end

  // Derived from registered state only, so reset releases SDA at once
  always_comb begin
    sda_oe = 1'b0;
    unique case (state_q)
      ADDR_ACK, ACK1, ACK2: sda_oe = 1'b1;
`ifdef I2C_SLV_READ_EN
      RD_BYTE: sda_oe = ~sh_q[7];
`endif
      default: ;
    endcase
  end

  assign I2C_SDAT  = sda_oe ? 1'b0 : 1'bz;
  assign oREG_WE   = we_q;
  assign oREG_ADDR = addr_q;
  assign oREG_DATA = data_q;
  assign oBUSY     = (state_q != IDLE);
  assign oACTIVE   = active_q;
  assign oDBG_DATA = shadow_q[iDBG_ADDR];

endmodule

// File: tb/tb_i2c_codec_slave.sv
// tb_i2c_codec_slave: bit-banged I2C master, reference model and
// strobe scoreboard for i2c_codec_slave.
`timescale 1ns/1ps
module tb_i2c_codec_slave;
  localparam int Q = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  logic [3:0] dbg_a = 4'd0;
  wire  sda;
  logic we, busy, active;
  logic [6:0] raddr;
  logic [8:0] rdata, dbg_d;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_codec_slave dut (
    .iCLK(clk), .iRST_N(rst_n),
    .I2C_SCLK(scl), .I2C_SDAT(sda),
    .oREG_WE(we), .oREG_ADDR(raddr),
    .oREG_DATA(rdata), .oBUSY(busy),
    .oACTIVE(active), .iDBG_ADDR(dbg_a),
    .oDBG_DATA(dbg_d)
  );

  always #10 clk = ~clk;

  int vec = 0;
  int bad = 0;
  logic [8:0]  m_sh [16];
  logic [6:0]  m_last;
  logic [8:0]  m_ldata;
  logic [15:0] exp_q [$];
  logic [7:0]  tx [8];
  int          tx_n;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      chk("strobe_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        chk("strobe_addr_data", {raddr, rdata},
            exp_q.pop_front());
    end
  end

  task automatic model_commit(input logic [6:0] ra,
                              input logic [8:0] d);
    exp_q.push_back({ra, d});
    m_last  = ra;
    m_ldata = d;
    if (ra < 7'd15)
      m_sh[ra[3:0]] = d;
    else if (ra == 7'd15)
      for (int i = 0; i < 15; i++) m_sh[i] = 9'h0;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 16; i++) m_sh[i] = 9'h0;
    m_last  = 7'h0;
    m_ldata = 9'h0;
  endtask

  task automatic check_regs;
    for (int i = 0; i < 16; i++) begin
      dbg_a = 4'(i);
      #1;
      chk($sformatf("shadow[%0d]", i), dbg_d, m_sh[i]);
    end
    chk("active", active, m_sh[9][0]);
    chk("reg_addr", raddr, m_last);
    chk("reg_data", rdata, m_ldata);
  endtask

  task automatic put_bit(input logic b);
    wq(Q); m_low = ~b;
    wq(Q); scl = 1'b1;
    wq(2*Q); scl = 1'b0;
  endtask

  task automatic clk_in(input logic drv_low, output logic s);
    wq(Q); m_low = drv_low;
    wq(Q); scl = 1'b1;
    wq(Q); s = sda;
    wq(Q); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    clk_in(1'b0, ack);
  endtask

  task automatic i2c_start;
    wq(Q); m_low = 1'b0;
    wq(Q); scl = 1'b1;
    wq(2*Q); m_low = 1'b1;
    wq(2*Q); scl = 1'b0;
  endtask

  task automatic i2c_stop;
    wq(Q); m_low = 1'b1;
    wq(Q); scl = 1'b1;
    wq(2*Q); m_low = 1'b0;
    wq(2*Q);
  endtask

  task automatic do_txn(input bit rs_end);
    logic a;
    bit match;
    i2c_start;
    chk("busy_after_start", busy, 1);
    match = (tx[0] == 8'h34);
    for (int i = 0; i < tx_n; i++) begin
      if (match && i == 2)
        model_commit(tx[1][7:1], {tx[1][0], tx[2]});
      send_byte(tx[i], a);
      chk($sformatf("ack[%0d]", i), a,
          !(match && i <= 2));
    end
    if (!rs_end) begin
      i2c_stop;
      wq(8);
      chk("busy_idle", busy, 0);
      check_regs;
    end
  endtask

  task automatic set3(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [7:0] c,
                      input logic [7:0] d,
                      input int n);
    tx[0] = a; tx[1] = b; tx[2] = c; tx[3] = d;
    tx_n = n;
  endtask

`ifdef I2C_SLV_READ_EN
  task automatic do_read;
    logic a, s;
    logic [7:0] b1, b2;
    logic [8:0] d;
    d = (m_last < 7'd15) ? m_sh[m_last[3:0]] : 9'h0;
    b1 = 8'h0;
    b2 = 8'h0;
    i2c_start;
    send_byte(8'h35, a);
    chk("rd_addr_ack", a, 0);
    for (int i = 0; i < 8; i++) begin
      clk_in(1'b0, s); b1 = {b1[6:0], s};
    end
    clk_in(1'b1, s);
    for (int i = 0; i < 8; i++) begin
      clk_in(1'b0, s); b2 = {b2[6:0], s};
    end
    clk_in(1'b0, s);
    i2c_stop;
    wq(8);
    chk("rd_byte1", b1, {m_last, d[8]});
    chk("rd_byte2", b2, d[7:0]);
    chk("busy_idle_rd", busy, 0);
  endtask
`endif

  initial begin
    logic a;
    logic [6:0] ra;
    int r;
    model_reset;
    wq(4);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda, 1);
    check_regs;
    rst_n = 1'b1;
    wq(5);

    set3(8'h34, 8'h00, 8'h1A, 8'h00, 3); do_txn(0);
    set3(8'h34, 8'h12, 8'h01, 8'h00, 3); do_txn(0);
    set3(8'h34, 8'h1E, 8'h00, 8'h00, 3); do_txn(0);
    set3(8'h36, 8'hAA, 8'h55, 8'h00, 3); do_txn(0);
    set3(8'h34, 8'h09, 8'h33, 8'h00, 3); do_txn(0);
    set3(8'h34, 8'h08, 8'h00, 8'h00, 2); do_txn(0);
    set3(8'h34, 8'h08, 8'h00, 8'h00, 2); do_txn(1);
    set3(8'h34, 8'h08, 8'hF8, 8'h00, 3); do_txn(0);
    set3(8'h34, 8'h0A, 8'h06, 8'h55, 4); do_txn(0);
`ifdef I2C_SLV_READ_EN
    set3(8'h34, 8'h08, 8'hF8, 8'h00, 3); do_txn(0);
    do_read;
`else
    set3(8'h35, 8'h08, 8'hF8, 8'h00, 3); do_txn(0);
`endif

    i2c_start;
    send_byte(8'h34, a);
    for (int i = 7; i >= 0; i--) put_bit(r[0] | 1'b1);
    wq(Q); m_low = 1'b0;
    wq(Q); scl = 1'b1;
    wq(Q);
    chk("ack1_driven", sda, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_sda_release", sda, 1);
    model_reset;
    wq(4);
    chk("rst_busy_mid", busy, 0);
    rst_n = 1'b1;
    wq(10);
    check_regs;

    for (int k = 0; k < 25; k++) begin
      r = $urandom_range(0, 9);
      tx[0] = (r < 7) ? 8'h34 : ((r < 9) ? 8'h36 : 8'hA0);
      r = $urandom_range(0, 7);
      if (r == 0)      ra = 7'h0F;
      else if (r == 1) ra = 7'($urandom_range(16, 127));
      else if (r == 2) ra = 7'h09;
      else             ra = 7'($urandom_range(0, 14));
      tx[1] = {ra, 1'($urandom)};
      for (int i = 2; i < 8; i++) tx[i] = 8'($urandom);
      tx_n = $urandom_range(0, 5);
      do_txn($urandom_range(0, 3) == 0);
    end
    i2c_stop;
    wq(8);
    check_regs;

    wq(20);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

endmodule

// File: doc/i2c_codec_slave.md
# i2c_codec_slave

I2C write-responder for the audio-codec control port. It emulates the codec side of the two-byte register protocol (7-bit register address plus 9-bit data) so the configuration master can be exercised in simulation and on the board without a physical codec. It is oversampled on the system clock, holds a 16-entry shadow register file, and pulses a write strobe per accepted register write.

## Interface
- SLAVE_ADDR, 7'h1A, 7-bit device address; the write address byte is 8'h34.
- iCLK  in  1  system clock (50 MHz nominal).
- iRST_N  in  1  reset, asynchronous, active-low.
- I2C_SCLK  in  1  I2C clock from the master.
- I2C_SDAT  inout  1  I2C data, open-drain: the block drives 1'b0 or 1'bz only.
- oREG_WE  out  1  one-cycle strobe when a register write is accepted.
- oREG_ADDR  out  7  register address of the last accepted write.
- oREG_DATA  out  9  data of the last accepted write.
- oBUSY  out  1  high from START until STOP or abort.
- oACTIVE  out  1  bit 0 of register 0x09.
- iDBG_ADDR  in  4  shadow register readback select.
- oDBG_DATA  out  9  combinational readback of shadow[iDBG_ADDR].

## Operation
- Inputs pass through two-flop synchronizers; edges are detected on the synchronized copies.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are valid in any state, including mid-byte.
- States: IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE, plus RD_BYTE and RD_ACK when reads are enabled.
- A START from any state goes to ADDR with the bit counter cleared, which covers repeated START.
- Bits are shifted in MSB first on the SCL rising edge.
- ADDR, after 8 bits:
  - If the top 7 bits equal SLAVE_ADDR and R/W=0: go to ADDR_ACK.
  - Otherwise: go to IGNORE with no ACK and SDA released.
- ACK phases: drive SDA low from the SCL falling edge after bit 8 until the next SCL falling edge.
- BYTE1 = {reg_addr[6:0], data[8]} and is always ACKed.
- BYTE2 = data[7:0]. On the SCL falling edge after its 8th bit:
  - The write commits.
  - oREG_WE pulses for one iCLK cycle.
  - oREG_ADDR and oREG_DATA update.
  - The ACK drive starts.
- Commit rules by reg_addr:
  - 0x00–0x0E: store into shadow[reg_addr].
  - 0x0F: clear shadow 0x00–0x0E to 9'h000. Nothing is stored at 0x0F.
  - 0x10–0x7F: no store, but still ACKed and still strobed.
- After ACK2, any further byte is NACKed and the FSM goes to IGNORE until START or STOP.
- STOP or START before the BYTE2 commit aborts the transaction with no write and no strobe.
- oBUSY is low in IDLE and high in every other state. STOP returns the FSM to IDLE.

## Timing
- Reset values:
  - oREG_WE=0, oREG_ADDR=0, oREG_DATA=0, oBUSY=0, oACTIVE=0.
  - All shadow registers are 0.
  - SDA is released (z) and the FSM is in IDLE.
- Reset mid-transfer releases SDA asynchronously.
- Latency from a bus edge to the internal reaction is 3 iCLK cycles (2 synchronizer cycles plus 1 edge-detect cycle).
- Requirement: SCL high and low phases must each be at least 8 iCLK cycles. At the 20 kHz bus rate this holds with large margin.
- SDA changes by the block occur only after a detected SCL falling edge, never while SCL is high.
- oDBG_DATA is purely combinational. oACTIVE is registered and follows shadow[9][0] in the cycle after commit.

## Configuration
- I2C_SLV_READ_EN defined (reads enabled):
  - An address byte with R/W=1 that matches SLAVE_ADDR is ACKed.
  - The block then shifts out, MSB first, the address of the last accepted write and its data:
    - Byte 1: {last_addr[6:0], shadow[last_addr][8]}.
    - Byte 2: shadow[last_addr][7:0].
  - Each output bit changes after an SCL falling edge.
  - The master's ACK after byte 1 continues to byte 2. A master NACK, or any byte after byte 2, goes to IGNORE.
  - If last_addr is 0x0F or above, the data portion reads as 0.
- I2C_SLV_READ_EN undefined: R/W=1 addresses are NACKed and the FSM goes to IGNORE. The RD states are not built.

## Test plan
- Write 0x34, 0x00, 0x1A, then STOP -> three ACKs; oREG_WE pulses once with oREG_ADDR=0x00, oREG_DATA=0x01A; iDBG_ADDR=0 reads 0x01A; oBUSY returns to 0.
- Write 0x34, 0x12, 0x01 -> shadow[9]=0x001 and oACTIVE=1. Then write 0x34, 0x1E, 0x00 -> shadow 0x00–0x0E all 0 and oACTIVE=0.
- Address 0x36 followed by 2 data bytes -> no ACK on any byte, no oREG_WE, SDA never driven.
- Write 0x34, 0x08, then STOP -> no strobe and shadow[4] unchanged. Repeat with a repeated START followed by 0x34, 0x08, 0xF8 -> shadow[4]=0x0F8.
- Write 0x34, 0x0A, 0x06, 0x55 -> first three bytes ACKed, fourth NACKed, exactly one strobe with data 0x006.
- With I2C_SLV_READ_EN: write 0x34, 0x08, 0xF8, then read 0x35 -> bytes 0x08 and 0xF8 returned. Without the macro, 0x35 is NACKed. Assert iRST_N low during byte 2 -> SDA released immediately and no strobe.
